// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PID encodings, receiver FSM states and the
// CRC5/CRC16 bit-serial step functions with their good-packet residuals.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HS,
    ST_DROP
  } rx_state_t;

  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // Bits enter LSB-first, matching UTMI byte order on the wire.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Bytewise CRC16 accumulator for DATAx packets; o_residual_ok flags a good
// residual once payload and transmitted CRC have both been absorbed.
module usb_crc16 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic       o_residual_ok
);
  import usb_pkg::*;

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '1;
    end else if (i_clr) begin
      r_crc <= '1;
    end else if (i_en) begin
      r_crc <= crc16_byte(r_crc, i_byte);
    end
  end

  assign o_residual_ok = (r_crc == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_pkt_rx.sv
// USB packet receiver behind the UTMI receive side: PID check, token/CRC5,
// DATAx streaming with CRC16 stripped, handshakes. Optional SOF decode: USB_RX_SOF_EN.
module usb_pkt_rx #(
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic        tok_valid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic        hs_valid,
  output logic        data_valid,
  output logic [7:0]  data,
  output logic        pkt_end,
  output logic        pkt_ok,
  output logic        err_pid,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_phy,
  output logic        sof_valid,
  output logic [10:0] frame_num
);
  import usb_pkg::*;

  localparam int unsigned    CW      = $clog2(MAX_PAYLOAD + 3) + 1;
  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [CW-1:0]  CNT_OVF = CW'(MAX_PAYLOAD + 2);

  rx_state_t     r_state;
  logic          r_rx_active_q;
  logic [3:0]    r_pid;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_h0;
  logic [7:0]    r_h1;
  logic [4:0]    r_crc5;
  logic          r_tok_valid;
  logic [6:0]    r_tok_addr;
  logic [3:0]    r_tok_endp;
  logic          r_hs_valid;
  logic          r_data_valid;
  logic [7:0]    r_data;
  logic          r_pkt_end;
  logic          r_pkt_ok;
  logic          r_err_pid;
  logic          r_err_crc;
  logic          r_err_len;
  logic          r_err_phy;
`ifdef USB_RX_SOF_EN
  logic          r_sof_valid;
  logic [10:0]   r_frame_num;
`endif

  logic          w_acc;
  logic          w_rise;
  logic          w_fall;
  logic          w_pid_cpl;
  logic [4:0]    w_crc5_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_crc16_ok;
  logic          w_crc_clr;
  logic          w_crc_en;
  logic          w_fin_pid;
  logic          w_fin_crc;
  logic          w_fin_len;
  logic          w_fin_phy;
  logic          w_fin_ok;

  assign w_acc     = rx_valid && rx_active;
  assign w_rise    = rx_active && !r_rx_active_q;
  assign w_fall    = !rx_active && r_rx_active_q;
  assign w_pid_cpl = (rx_data[7:4] == ~rx_data[3:0]);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_crc_clr = (r_state == ST_PID) && w_acc;
  assign w_crc_en  = (r_state == ST_DATA) && w_acc && !rx_error;

  always_comb begin
    w_crc5_next = r_crc5;
    for (int unsigned i = 0; i < 8; i++) begin
      w_crc5_next = crc5_step(w_crc5_next, rx_data[i]);
    end
  end

  usb_crc16 u_crc16 (
    .clk          (clk),
    .rst_n        (rst),
    .i_clr        (w_crc_clr),
    .i_en         (w_crc_en),
    .i_byte       (rx_data),
    .o_residual_ok(w_crc16_ok)
  );

  // Final status folds the end-of-packet length/CRC checks into the sticky flags.
  always_comb begin
    w_fin_pid = r_err_pid || (r_state == ST_PID);
    w_fin_phy = r_err_phy || rx_error;
    w_fin_len = r_err_len
             || ((r_state == ST_TOKEN) && (r_cnt != CW'(2)))
             || ((r_state == ST_HS)    && (r_cnt != '0))
             || ((r_state == ST_DATA)  && (r_cnt <  CW'(2)));
    w_fin_crc = r_err_crc
             || ((r_state == ST_TOKEN) && (r_cnt == CW'(2)) && (r_crc5 != CRC5_RESIDUAL))
             || ((r_state == ST_DATA)  && (r_cnt >= CW'(2)) && !w_crc16_ok);
    w_fin_ok  = !(w_fin_pid || w_fin_phy || w_fin_len || w_fin_crc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_rx_active_q <= 1'b1;
      r_pid         <= '0;
      r_cnt         <= '0;
      r_h0          <= '0;
      r_h1          <= '0;
      r_crc5        <= '1;
      r_tok_valid   <= 1'b0;
      r_tok_addr    <= '0;
      r_tok_endp    <= '0;
      r_hs_valid    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data        <= '0;
      r_pkt_end     <= 1'b0;
      r_pkt_ok      <= 1'b0;
      r_err_pid     <= 1'b0;
      r_err_crc     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_phy     <= 1'b0;
`ifdef USB_RX_SOF_EN
      r_sof_valid   <= 1'b0;
      r_frame_num   <= '0;
`endif
    end else begin
      r_rx_active_q <= rx_active;
      r_tok_valid   <= 1'b0;
      r_hs_valid    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_pkt_end     <= 1'b0;
`ifdef USB_RX_SOF_EN
      r_sof_valid   <= 1'b0;
`endif
      if (r_state == ST_IDLE) begin
        if (w_rise) r_state <= ST_PID;
      end else if (w_fall) begin
        r_state   <= ST_IDLE;
        r_pkt_end <= 1'b1;
        r_pkt_ok  <= w_fin_ok;
        r_err_pid <= w_fin_pid;
        r_err_crc <= w_fin_crc;
        r_err_len <= w_fin_len;
        r_err_phy <= w_fin_phy;
        if (w_fin_ok && (r_state == ST_HS)) r_hs_valid <= 1'b1;
        if (w_fin_ok && (r_state == ST_TOKEN)) begin
          if (r_pid != PID_SOF) begin
            r_tok_valid <= 1'b1;
            r_tok_addr  <= r_h1[6:0];
            r_tok_endp  <= {r_h0[2:0], r_h1[7]};
          end
`ifdef USB_RX_SOF_EN
          else begin
            r_sof_valid <= 1'b1;
            r_frame_num <= {r_h0[2:0], r_h1};
          end
`endif
        end
      end else if (rx_error) begin
        r_err_phy <= 1'b1;
        r_state   <= ST_DROP;
      end else if (w_acc) begin
        case (r_state)
          ST_PID: begin
            r_pid     <= rx_data[3:0];
            r_err_pid <= 1'b0;
            r_err_crc <= 1'b0;
            r_err_len <= 1'b0;
            r_err_phy <= 1'b0;
            r_cnt     <= '0;
            r_crc5    <= '1;
            if (!w_pid_cpl) begin
              r_err_pid <= 1'b1;
              r_state   <= ST_DROP;
            end else begin
              case (rx_data[3:0])
                PID_OUT, PID_IN, PID_SETUP, PID_SOF: r_state <= ST_TOKEN;
                PID_DATA0, PID_DATA1:                r_state <= ST_DATA;
                PID_ACK, PID_NAK, PID_STALL:         r_state <= ST_HS;
                default: begin
                  r_err_pid <= 1'b1;
                  r_state   <= ST_DROP;
                end
              endcase
            end
          end
          ST_TOKEN, ST_HS: begin
            r_h0   <= rx_data;
            r_h1   <= r_h0;
            r_cnt  <= w_cnt_inc;
            r_crc5 <= w_crc5_next;
          end
          ST_DATA: begin
            r_h0  <= rx_data;
            r_h1  <= r_h0;
            r_cnt <= w_cnt_inc;
            // Two newest bytes stay held back: they may turn out to be the CRC.
            if (r_cnt >= CW'(2)) begin
              if (r_cnt >= CNT_OVF) begin
                r_err_len <= 1'b1;
              end else begin
                r_data_valid <= 1'b1;
                r_data       <= r_h1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pid        = r_pid;
  assign tok_valid  = r_tok_valid;
  assign tok_addr   = r_tok_addr;
  assign tok_endp   = r_tok_endp;
  assign hs_valid   = r_hs_valid;
  assign data_valid = r_data_valid;
  assign data       = r_data;
  assign pkt_end    = r_pkt_end;
  assign pkt_ok     = r_pkt_ok;
  assign err_pid    = r_err_pid;
  assign err_crc    = r_err_crc;
  assign err_len    = r_err_len;
  assign err_phy    = r_err_phy;
`ifdef USB_RX_SOF_EN
  assign sof_valid  = r_sof_valid;
  assign frame_num  = r_frame_num;
`else
  assign sof_valid  = 1'b0;
  assign frame_num  = '0;
`endif

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Directed bench for usb_pkt_rx (MAX_PAYLOAD overridden to 8 to reach the
// overflow boundary); SOF expectations follow USB_RX_SOF_EN.
module tb_usb_pkt_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_error = 1'b0;
  logic [3:0]  pid;
  logic        tok_valid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic        hs_valid;
  logic        data_valid;
  logic [7:0]  data;
  logic        pkt_end;
  logic        pkt_ok;
  logic        err_pid;
  logic        err_crc;
  logic        err_len;
  logic        err_phy;
  logic        sof_valid;
  logic [10:0] frame_num;

  usb_pkt_rx #(.MAX_PAYLOAD(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .rx_error(rx_error), .pid(pid),
    .tok_valid(tok_valid), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .hs_valid(hs_valid), .data_valid(data_valid), .data(data),
    .pkt_end(pkt_end), .pkt_ok(pkt_ok), .err_pid(err_pid), .err_crc(err_crc),
    .err_len(err_len), .err_phy(err_phy), .sof_valid(sof_valid),
    .frame_num(frame_num)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor: cumulative event counts and status captured at pkt_end.
  int          m_cyc = 0, m_end = 0, m_tok = 0, m_hs = 0, m_sof = 0, m_stray = 0;
  int          m_dv_cyc = -1, m_end_cyc = -1;
  logic [7:0]  m_data[$];
  logic        s_ok, s_epid, s_ecrc, s_elen, s_ephy;
  logic [3:0]  s_pid, s_endp;
  logic [6:0]  s_addr;
  logic [10:0] s_frame;

  always @(negedge clk) begin
    m_cyc++;
    if (data_valid) begin
      m_data.push_back(data);
      m_dv_cyc = m_cyc;
    end
    if (tok_valid) m_tok++;
    if (hs_valid)  m_hs++;
    if (sof_valid) m_sof++;
    if ((tok_valid || hs_valid || sof_valid) && !pkt_end) m_stray++;
    if (pkt_end) begin
      m_end++;
      m_end_cyc = m_cyc;
      s_ok = pkt_ok; s_epid = err_pid; s_ecrc = err_crc; s_elen = err_len;
      s_ephy = err_phy; s_pid = pid; s_addr = tok_addr; s_endp = tok_endp;
      s_frame = frame_num;
    end
  end

  int b_end, b_tok, b_hs, b_sof, b_dat;
  logic [7:0] pkt[$];
  logic [7:0] exp_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    b_end = m_end; b_tok = m_tok; b_hs = m_hs; b_sof = m_sof; b_dat = m_data.size();
  endtask

  // Drives pkt[] as one packet; err_idx >= 0 replaces that byte with an rx_error pulse.
  task automatic send(input int err_idx);
    mark();
    @(posedge clk); #1 rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == err_idx) begin
        rx_error = 1'b1;
        @(posedge clk); #1 rx_error = 1'b0;
        break;
      end
      rx_data = pkt[i]; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_active = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_data(input string tag);
    check({tag, "_count"}, 32'(m_data.size() - b_dat), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && (b_dat + i) < m_data.size(); i++)
      check({tag, "_byte"}, 32'(m_data[b_dat + i]), 32'(exp_d[i]));
  endtask

  function automatic logic [7:0] tok_b2(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    c = ~c;
    return {c[0], c[1], c[2], c[3], c[4], d[10:8]};
  endfunction

  logic [10:0] tw;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pid", 32'(pid), 32'h0);
    check("rst_flags", 32'({pkt_end, pkt_ok, tok_valid, hs_valid, data_valid,
                            err_pid, err_crc, err_len, err_phy, sof_valid}), 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // SETUP addr 0 endp 0
    pkt = '{8'h2D, 8'h00, 8'h10};
    send(-1);
    check("setup_end", 32'(m_end - b_end), 32'd1);
    check("setup_tok", 32'(m_tok - b_tok), 32'd1);
    check("setup_pid", 32'(s_pid), 32'hD);
    check("setup_addr", 32'(s_addr), 32'h0);
    check("setup_endp", 32'(s_endp), 32'h0);
    check("setup_ok", 32'(s_ok), 32'd1);

    // IN addr 3A endp A, CRC5 generated
    tw = {4'hA, 7'h3A};
    pkt = '{8'h69, tw[7:0], tok_b2(tw)};
    send(-1);
    check("in_tok", 32'(m_tok - b_tok), 32'd1);
    check("in_addr", 32'(s_addr), 32'h3A);
    check("in_endp", 32'(s_endp), 32'hA);
    check("in_pid", 32'(s_pid), 32'h9);

    // Corrupted CRC5
    pkt = '{8'h69, tw[7:0], tok_b2(tw) ^ 8'h08};
    send(-1);
    check("in_bad_crc", 32'({s_ecrc, s_ok}), 32'b10);
    check("in_bad_tok", 32'(m_tok - b_tok), 32'd0);

    // Short token
    pkt = '{8'hE1, 8'h00};
    send(-1);
    check("out_short_len", 32'({s_elen, s_ok}), 32'b10);

    // DATA0 8-byte payload (exactly MAX_PAYLOAD)
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    exp_d = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    send(-1);
    check_data("d0");
    check("d0_ok", 32'({s_ok, s_ecrc, s_elen}), 32'b100);
    check("d0_end", 32'(m_end - b_end), 32'd1);
    check("d0_dv_before_end", 32'(m_dv_cyc < m_end_cyc), 32'd1);

    pkt[10] = 8'h95;
    send(-1);
    check("d0_badcrc", 32'({s_ecrc, s_ok}), 32'b10);

    // 9-byte payload exceeds MAX_PAYLOAD: only 8 emitted
    pkt = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(-1);
    check_data("ovf");
    check("ovf_len", 32'({s_elen, s_ok}), 32'b10);

    // ACK, then ACK with trailing byte
    pkt = '{8'hD2};
    send(-1);
    check("ack_hs", 32'(m_hs - b_hs), 32'd1);
    check("ack_pid", 32'(s_pid), 32'h2);
    check("ack_ok", 32'(s_ok), 32'd1);
    pkt = '{8'hD2, 8'h00};
    send(-1);
    check("ack_long_hs", 32'(m_hs - b_hs), 32'd0);
    check("ack_long_len", 32'({s_elen, s_ok}), 32'b10);

    // Bad PID complement
    pkt = '{8'h2E, 8'h00, 8'h10};
    send(-1);
    check("badpid_err", 32'({s_epid, s_ok}), 32'b10);
    check("badpid_end", 32'(m_end - b_end), 32'd1);
    check("badpid_tok", 32'(m_tok - b_tok), 32'd0);
    check("badpid_dv", 32'(m_data.size() - b_dat), 32'd0);

    // Zero-length DATA1
    pkt = '{8'h4B, 8'h00, 8'h00};
    send(-1);
    check("zlp_dv", 32'(m_data.size() - b_dat), 32'd0);
    check("zlp_ok", 32'(s_ok), 32'd1);
    check("zlp_pid", 32'(s_pid), 32'hB);

    // PHY error mid DATA0
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
    send(3);
    check("phy_err", 32'({s_ephy, s_ok}), 32'b10);
    check("phy_end", 32'(m_end - b_end), 32'd1);

    // SOF frame 0, then frame 5A3
    pkt = '{8'hA5, 8'h00, 8'h10};
    send(-1);
    check("sof0_tok", 32'(m_tok - b_tok), 32'd0);
    check("sof0_ok", 32'(s_ok), 32'd1);
`ifdef USB_RX_SOF_EN
    check("sof0_valid", 32'(m_sof - b_sof), 32'd1);
    check("sof0_frame", 32'(s_frame), 32'h0);
`else
    check("sof0_valid", 32'(m_sof - b_sof), 32'd0);
`endif
    tw = 11'h5A3;
    pkt = '{8'hA5, tw[7:0], tok_b2(tw)};
    send(-1);
    check("sof1_ok", 32'(s_ok), 32'd1);
`ifdef USB_RX_SOF_EN
    check("sof1_frame", 32'(s_frame), 32'h5A3);
`else
    check("sof1_frame", 32'(s_frame), 32'h0);
`endif

    // rx_valid with rx_active low is ignored
    mark();
    @(posedge clk); #1 rx_data = 8'hD2; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_valid_end", 32'(m_end - b_end), 32'd0);

    // Reset asserted mid-packet: that packet produces no pkt_end
    mark();
    @(posedge clk); #1 rx_active = 1'b1;
    @(posedge clk); #1 rx_data = 8'hC3; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h5A; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_active = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_end", 32'(m_end - b_end), 32'd0);
    check("rstmid_pid", 32'(pid), 32'h0);
    pkt = '{8'h5A};
    send(-1);
    check("post_rst_hs", 32'(m_hs - b_hs), 32'd1);
    check("post_rst_pid", 32'({s_pid, s_ok}), 32'({4'hA, 1'b1}));

    check("stray_pulses", 32'(m_stray), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
